// File: rtl/ascon_ad_block_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ascon_pkg
// Description : Shared types and constants for the Ascon associated-data
//               block loader: FSM state encoding, rate sizes, pad byte and
//               a helper that maps sel_type to the block rate in bytes.
// Revision    : 1.0  initial release
// ============================================================================
package ascon_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    EMIT = 3'd2,
    PAD  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [4:0] RATE_128A = 5'd16;
  localparam logic [4:0] RATE_128  = 5'd8;
  localparam logic [7:0] PAD_BYTE  = 8'h01;

  // Only sel_type == 1 selects the 16-byte rate; every other code is 8 bytes.
  function automatic logic [4:0] rate_of(input logic [1:0] sel);
    return (sel == 2'd1) ? RATE_128A : RATE_128;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_ad_block_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : ascon_ad_block_loader_if
// Description : Word-stream input and block-stream output of the AD loader.
//   in_data/in_bytes/in_last/in_valid : word stream into the loader
//   in_ready                          : loader accepts a word
//   blk_data/blk_position/blk_length/blk_last/blk_valid : block stream out
//   blk_ready                         : downstream accepts a block
//   modport master : stream producer / block consumer (testbench, upstream)
//   modport slave  : the loader itself
// Revision    : 1.0  initial release
// ============================================================================
interface ascon_ad_block_loader_if #(
  parameter int LEN_W = 33
);
  logic [31:0]      in_data;
  logic [2:0]       in_bytes;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     blk_data;
  logic [LEN_W-1:0] blk_position;
  logic [LEN_W-1:0] blk_length;
  logic             blk_last;
  logic             blk_valid;
  logic             blk_ready;

  modport master (
    output in_data, in_bytes, in_last, in_valid, blk_ready,
    input  in_ready, blk_data, blk_position, blk_length, blk_last, blk_valid
  );

  modport slave (
    input  in_data, in_bytes, in_last, in_valid, blk_ready,
    output in_ready, blk_data, blk_position, blk_length, blk_last, blk_valid
  );
endinterface
`default_nettype wire

// File: rtl/ascon_ad_block_loader_lane_insert.sv
`default_nettype none
// ============================================================================
// Module      : ascon_byte_lane_insert
// Description : Combinational. Writes the first nbytes bytes of word into a
//               128-bit block starting at byte offset. Block byte b lives in
//               lane b/8 (lane 0 = [127:64], lane 1 = [63:0]) at bits
//               [8*(b%8)+7 : 8*(b%8)] within the lane. Bytes that would land
//               beyond byte 15 are dropped.
//   blk_in  in  128  block before insertion
//   word    in  32   source bytes, byte k at [8k+7:8k]
//   nbytes  in  3    number of bytes to write (0..4)
//   offset  in  5    first destination byte index
//   blk_out out 128  block after insertion
// Revision    : 1.0  initial release
// ============================================================================
module ascon_byte_lane_insert (
  input  wire logic [127:0] blk_in,
  input  wire logic [31:0]  word,
  input  wire logic [2:0]   nbytes,
  input  wire logic [4:0]   offset,
  output logic      [127:0] blk_out
);
  for (genvar b = 0; b < 16; b++) begin : g_byte
    localparam int BASE = (b < 8) ? (64 + 8 * b) : (8 * (b - 8));
    logic [4:0] rel;
    logic       hit;
    // rel wraps when b < offset; the offset compare rejects that case.
    assign rel     = 5'(b) - offset;
    assign hit     = (offset <= 5'(b)) && (rel < {2'b00, nbytes});
    assign blk_out[BASE +: 8] = hit ? word[{rel[1:0], 3'b000} +: 8]
                                    : blk_in[BASE +: 8];
  end
endmodule
`default_nettype wire

// File: rtl/ascon_ad_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : ascon_ad_block_loader
// Description : Packs a 32-bit little-endian AD byte stream into Ascon
//               rate-sized blocks (16 bytes for sel_type==1, else 8),
//               applies 0x01 padding and emits each block with its byte
//               position and the total AD length.
//   clk, rst   : clock, synchronous active-high reset
//   start      : latch ad_length/sel_type when idle
//   sel_type   : rate select
//   ad_length  : total AD bytes
//   bus        : ascon_ad_block_loader_if.slave (word in / block out)
//   done       : one-cycle pulse at end of message
//   err        : sticky protocol error
// Configuration: define ASCON_AD_CHECK_EN to enable in_bytes/in_last
//               checking on err; otherwise err is tied low and the byte
//               count of every word comes from ad_length alone.
// Revision    : 1.0  initial release
// ============================================================================
module ascon_ad_block_loader
  import ascon_pkg::*;
#(
  parameter int LEN_W = 33
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic [1:0]       sel_type,
  input  wire logic [LEN_W-1:0] ad_length,
  ascon_ad_block_loader_if.slave bus,
  output logic                  done,
  output logic                  err
);
  localparam logic [127:0] PAD_BLOCK = {56'h0, PAD_BYTE, 64'h0};

  state_t           state, state_next;
  logic [4:0]       cnt, rate, cnt_after;
  logic [LEN_W-1:0] remaining, position, length, rem_after;
  logic [127:0]     block, data_ins, pad_ins;
  logic             last;
  logic [2:0]       take;
  logic             exhaust, pad_here;
  logic             in_ready_c, blk_valid_c, done_c;

  // Byte count of the current word always follows the remaining length.
  assign take      = (remaining >= LEN_W'(4)) ? 3'd4 : remaining[2:0];
  assign cnt_after = cnt + {2'b00, take};
  assign rem_after = remaining - LEN_W'(take);
  assign exhaust   = (rem_after == '0);
  // Partial final block: the pad byte goes right after the last data byte.
  assign pad_here  = exhaust && (cnt_after < rate);

  ascon_byte_lane_insert u_data_insert (
    .blk_in (block),
    .word   (bus.in_data),
    .nbytes (take),
    .offset (cnt),
    .blk_out(data_ins)
  );

  ascon_byte_lane_insert u_pad_insert (
    .blk_in (data_ins),
    .word   ({24'h0, PAD_BYTE}),
    .nbytes (3'd1),
    .offset (cnt_after),
    .blk_out(pad_ins)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    blk_valid_c = 1'b0;
    done_c      = 1'b0;
    case (state)
      IDLE: if (start) state_next = (ad_length == '0) ? DONE : FILL;
      FILL: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && (exhaust || cnt_after == rate)) state_next = EMIT;
      end
      EMIT: begin
        blk_valid_c = 1'b1;
        if (bus.blk_ready) begin
          if (last)                 state_next = DONE;
          else if (remaining == '0) state_next = PAD;   // length % R == 0
          else                      state_next = FILL;
        end
      end
      PAD:     state_next = EMIT;
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rate      <= '0;
      remaining <= '0;
      position  <= '0;
      length    <= '0;
      block     <= '0;
      last      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          length    <= ad_length;
          remaining <= ad_length;
          rate      <= rate_of(sel_type);
          position  <= '0;
          cnt       <= '0;
          block     <= '0;
          last      <= 1'b0;
        end
        FILL: if (bus.in_valid) begin
          block     <= pad_here ? pad_ins : data_ins;
          cnt       <= cnt_after;
          remaining <= rem_after;
          if (pad_here) last <= 1'b1;
        end
        EMIT: if (bus.blk_ready && !last && remaining != '0) begin
          position <= position + LEN_W'(rate);
          cnt      <= '0;
          block    <= '0;
        end
        PAD: begin
          block    <= PAD_BLOCK;
          position <= position + LEN_W'(rate);
          last     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ASCON_AD_CHECK_EN
  logic bad_word;
  logic err_q;

  always_comb begin
    bad_word = 1'b0;
    if (bus.in_bytes == 3'd0 || bus.in_bytes > 3'd4)           bad_word = 1'b1;
    if (bus.in_bytes != take)                                  bad_word = 1'b1;
    if (bus.in_last && remaining != LEN_W'(bus.in_bytes))      bad_word = 1'b1;
    if (!bus.in_last && exhaust)                               bad_word = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                       err_q <= 1'b0;
    else if (state == IDLE && start)               err_q <= 1'b0;
    else if (state == FILL && bus.in_valid && bad_word) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_ok;
  assign unused_ok = ^{bus.in_bytes, bus.in_last};
  assign err       = 1'b0;
`endif

  assign bus.in_ready     = in_ready_c;
  assign bus.blk_valid    = blk_valid_c;
  assign bus.blk_data     = block;
  assign bus.blk_position = position;
  assign bus.blk_length   = length;
  assign bus.blk_last     = last;
  assign done             = done_c;

endmodule
`default_nettype wire

// File: tb/tb_ascon_ad_block_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ascon_ad_block_loader
// Description : Self-checking bench for ascon_ad_block_loader. A byte-level
//               reference model slices each message into rate-sized blocks,
//               pads, and packs them; random word pacing and block
//               back-pressure drive the DUT and every accepted block is
//               compared with the model. Directed cases cover reset, zero
//               length, a stall in EMIT, reset mid-message and the
//               ASCON_AD_CHECK_EN error flag.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ascon_ad_block_loader;
  localparam int LEN_W = 33;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       sel_type = 2'd0;
  logic [LEN_W-1:0] ad_length = '0;
  logic             done;
  logic             err;

  ascon_ad_block_loader_if #(.LEN_W(LEN_W)) bus ();

  ascon_ad_block_loader #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sel_type (sel_type),
    .ad_length(ad_length),
    .bus      (bus),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   msg [256];
  logic [127:0] exp_data [$];
  int           exp_pos  [$];
  bit           exp_last [$];
  logic [127:0] got_data [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [7:0] bb [16]);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) v[64 + 8 * i +: 8] = bb[i];
      else       v[8 * (i - 8) +: 8] = bb[i];
    end
    return v;
  endfunction

  // Reference: cut the message into R-byte slices, pad the short tail with
  // 0x01, or append a lone pad block when the length is a multiple of R.
  task automatic build_model(input int len, input int r);
    logic [7:0] bb [16];
    int n;
    exp_data.delete(); exp_pos.delete(); exp_last.delete();
    for (int p = 0; p < len; p += r) begin
      n = (len - p < r) ? (len - p) : r;
      for (int i = 0; i < 16; i++) bb[i] = (i < n) ? msg[p + i] : 8'h00;
      if (n < r) bb[n] = 8'h01;
      exp_data.push_back(pack(bb));
      exp_pos.push_back(p);
      exp_last.push_back(n < r);
    end
    if (len > 0 && len % r == 0) begin
      for (int i = 0; i < 16; i++) bb[i] = 8'h00;
      bb[0] = 8'h01;
      exp_data.push_back(pack(bb));
      exp_pos.push_back(len);
      exp_last.push_back(1'b1);
    end
  endtask

  task automatic run_msg(input int sel, input int len, input int ready_pct,
                         input bit stall, input bit corrupt);
    int r, sent, seen, n;
    bit got_done, stalled, exp_valid_next, first_word, exp_err;
    logic [127:0] snap_d;
    logic [LEN_W-1:0] snap_p;
    logic snap_l;
    r = (sel == 1) ? 16 : 8;
`ifdef ASCON_AD_CHECK_EN
    exp_err = corrupt && (len > 4);
`else
    exp_err = 1'b0;
`endif
    build_model(len, r);
    got_data.delete();
    n = 0;
    @(negedge clk);
    sel_type = 2'(sel); ad_length = LEN_W'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0; sel_type = 2'($urandom); ad_length = LEN_W'($urandom);
    sent = 0; seen = 0; got_done = 0; stalled = 0; exp_valid_next = 0; first_word = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (exp_valid_next) check("blk_latency", 128'(bus.blk_valid), 128'd1);
      exp_valid_next = 0;
      if (done) begin
        got_done = 1;
        break;
      end
      if (stall && !stalled && bus.blk_valid) begin
        stalled = 1;
        snap_d = bus.blk_data; snap_p = bus.blk_position; snap_l = bus.blk_last;
        bus.blk_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_data", bus.blk_data, snap_d);
          check("stall_pos", 128'(bus.blk_position), 128'(snap_p));
          check("stall_last", 128'(bus.blk_last), 128'(snap_l));
          check("stall_valid", 128'(bus.blk_valid), 128'd1);
          check("stall_in_ready", 128'(bus.in_ready), 128'd0);
        end
      end
      bus.blk_ready = ($urandom_range(99) < 32'(ready_pct));
      if (sent < len) begin
        n = (len - sent < 4) ? (len - sent) : 4;
        bus.in_valid = 1'($urandom_range(1));
        bus.in_data  = $urandom;
        for (int i = 0; i < n; i++) bus.in_data[8 * i +: 8] = msg[sent + i];
        bus.in_bytes = (corrupt && first_word && len > 4) ? 3'd3 : 3'(n);
        bus.in_last  = (sent + n == len);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.blk_valid) begin
        check("in_ready_in_emit", 128'(bus.in_ready), 128'd0);
        if (bus.blk_ready) begin
          if (seen < exp_data.size()) begin
            check("blk_data", bus.blk_data, exp_data[seen]);
            check("blk_position", 128'(bus.blk_position), 128'(exp_pos[seen]));
            check("blk_last", 128'(bus.blk_last), 128'(exp_last[seen]));
            check("blk_length", 128'(bus.blk_length), 128'(len));
          end else begin
            check("extra_block", 128'd1, 128'd0);
          end
          got_data.push_back(bus.blk_data);
          seen++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        first_word = 0;
        if ((sent + n) % r == 0 || sent + n == len) exp_valid_next = 1;
        sent += n;
      end
      @(negedge clk);
    end
    check("done_seen", 128'(got_done), 128'd1);
    check("block_count", 128'(seen), 128'(exp_data.size()));
    check("err_flag", 128'(err), 128'(exp_err));
    bus.in_valid = 1'b0; bus.blk_ready = 1'b0;
    @(negedge clk);
    check("done_pulse_width", 128'(done), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd0);
    check({tag, "_blk_valid"}, 128'(bus.blk_valid), 128'd0);
    check({tag, "_blk_last"}, 128'(bus.blk_last), 128'd0);
    check({tag, "_blk_data"}, bus.blk_data, 128'd0);
    check({tag, "_blk_pos"}, 128'(bus.blk_position), 128'd0);
    check({tag, "_blk_len"}, 128'(bus.blk_length), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
    check({tag, "_err"}, 128'(err), 128'd0);
  endtask

  initial begin
    string s;
    int len;
    bus.in_data = '0; bus.in_bytes = 3'd0; bus.in_last = 1'b0;
    bus.in_valid = 1'b0; bus.blk_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // 62-byte text, 16-byte rate
    s = {"This is my test for processing associated data tep", "t and abstor"};
    for (int i = 0; i < 62; i++) msg[i] = s[i];
    run_msg(1, 62, 100, 1'b0, 1'b0);
    check("t1_nblocks", 128'(got_data.size()), 128'd4);
    if (got_data.size() > 0) check("t1_blk0", got_data[0], 128'h2073692073696854_207473657420796d);
    else                     check("t1_blk0_missing", 128'd0, 128'd1);

    // 16 bytes, 16-byte rate: data block then lone pad block; with a stall
    for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
    run_msg(1, 16, 70, 1'b1, 1'b0);
    if (got_data.size() > 1) check("t2_pad_blk", got_data[1], 128'h0000000000000001_0000000000000000);
    else                     check("t2_pad_missing", 128'd0, 128'd1);

    // 5 bytes, 8-byte rate
    for (int i = 0; i < 5; i++) msg[i] = 8'(i + 1);
    run_msg(0, 5, 100, 1'b0, 1'b0);
    if (got_data.size() > 0) check("t3_blk", got_data[0], 128'h0000010504030201_0000000000000000);
    else                     check("t3_missing", 128'd0, 128'd1);

    // Zero length: no block, done one cycle after start
    @(negedge clk);
    sel_type = 2'd1; ad_length = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 128'(done), 128'd1);
    check("zero_no_blk", 128'(bus.blk_valid), 128'd0);
    @(negedge clk);
    check("zero_done_width", 128'(done), 128'd0);
    check("zero_no_blk2", 128'(bus.blk_valid), 128'd0);

    // Randomized messages, various rates, pacing, stalls and bad in_bytes
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(70, 1);
      for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
      run_msg(int'($urandom_range(3)), len, int'($urandom_range(100, 30)),
              (t % 5 == 0), (t % 4 == 1));
    end

    // Reset mid-FILL aborts with no done pulse
    @(negedge clk);
    sel_type = 2'd1; ad_length = LEN_W'(40); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_5A5A; bus.in_bytes = 3'd4; bus.in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("midfill_in_ready", 128'(bus.in_ready), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0; bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_done", 128'(done), 128'd0);
      check("midrst_idle", 128'(bus.in_ready), 128'd0);
    end

    // start together with rst: rst wins
    rst = 1'b1; start = 1'b1; ad_length = LEN_W'(20); sel_type = 2'd0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_wins_len", 128'(bus.blk_length), 128'd0);
    @(negedge clk);
    check("rst_wins_idle", 128'(bus.in_ready), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
